polar_gen_row_streamer: RTL and testbench

- Parametrised successor to the partial-sums generator-matrix row source for the semi-parallel SC decoder.
- Streams rows of G_N = F^{⊗n}, with F = [[1,0],[1,1]] and N = 2^n.
- Generalised over the sequential-only generator:
  - arbitrary start row with wrap-around;
  - programmable row count;
  - optional bit-reversed row order;
  - valid/ready back-pressure, abort and done signalling.
- Feeds the partial-sum update logic, one row per accepted beat.

---
 rtl/polar_gen_row_streamer.sv | 154 +++++++++++++++
 tb/tb_polar_gen_row_streamer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/polar_gen_row_streamer.sv
`default_nettype none
// ============================================================================
// polar_gen_row_streamer : streams rows of G_N = F^{(x)n} with valid/ready
// Revision: 1.0
// ============================================================================
module polar_gen_row_streamer #(
  parameter int N_LOG = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N_LOG-1:0]        start_row,
  input  logic [N_LOG:0]          row_count,
  input  logic                    bitrev,
  input  logic                    row_ready,
  output logic                    row_valid,
  output logic [(1<<N_LOG)-1:0]   row_data,
  output logic [N_LOG-1:0]        row_idx,
  output logic                    row_last,
  output logic                    busy,
  output logic                    done
);

  localparam int             N     = 1 << N_LOG;
  localparam logic [N_LOG:0] N_CNT = (N_LOG+1)'(N);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [N_LOG-1:0]   k_q, k_d;
  logic [N_LOG-1:0]   start_row_q, start_row_d;
  logic               bitrev_q, bitrev_d;
  logic [N_LOG-1:0]   last_k_q, last_k_d;
  logic               row_valid_q, row_valid_d;
  logic [N-1:0]       row_data_q, row_data_d;
  logic [N_LOG-1:0]   row_idx_q, row_idx_d;
  logic               row_last_q, row_last_d;
  logic               done_q, done_d;

  logic [N_LOG-1:0]   k_inc;
  logic [N_LOG-1:0]   nat_r;
  logic               use_rev;
  logic [N_LOG-1:0]   eff_r;
  logic [N_LOG-1:0]   cnt_m1;

  function automatic logic [N_LOG-1:0] rev_bits(input logic [N_LOG-1:0] r);
    logic [N_LOG-1:0] v;
    for (int b = 0; b < N_LOG; b++) v[b] = r[N_LOG-1-b];
    return v;
  endfunction

  // Row e of the Kronecker power: column j is set iff j is a bit-subset of e.
  function automatic logic [N-1:0] gen_row(input logic [N_LOG-1:0] e);
    logic [N-1:0] row;
    for (int j = 0; j < N; j++) row[j] = ((N_LOG'(j) & ~e) == '0);
    return row;
  endfunction

  // In IDLE the candidate row is the one a start would launch; in RUN it is the successor.
  assign k_inc   = k_q + N_LOG'(1);
  assign nat_r   = (state_q == IDLE) ? start_row : (start_row_q + k_inc);
  assign use_rev = (state_q == IDLE) ? bitrev : bitrev_q;
  assign eff_r   = use_rev ? rev_bits(nat_r) : nat_r;
  assign cnt_m1  = ((row_count == '0) || (row_count >= N_CNT)) ? '1
                                                               : (row_count[N_LOG-1:0] - N_LOG'(1));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    start_row_d = start_row_q;
    bitrev_d    = bitrev_q;
    last_k_d    = last_k_q;
    row_valid_d = row_valid_q;
    row_data_d  = row_data_q;
    row_idx_d   = row_idx_q;
    row_last_d  = row_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = RUN;
          start_row_d = start_row;
          bitrev_d    = bitrev;
          last_k_d    = cnt_m1;
          k_d         = '0;
          row_valid_d = 1'b1;
          row_idx_d   = eff_r;
          row_data_d  = gen_row(eff_r);
          row_last_d  = (cnt_m1 == '0);
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          row_valid_d = 1'b0;
          row_last_d  = 1'b0;
        end else if (row_valid_q && row_ready) begin
          if (row_last_q) begin
            state_d     = IDLE;
            row_valid_d = 1'b0;
            row_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            k_d        = k_inc;
            row_idx_d  = eff_r;
            row_data_d = gen_row(eff_r);
            row_last_d = (k_inc == last_k_q);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        row_valid_d = 1'b0;
        row_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      start_row_q <= '0;
      bitrev_q    <= 1'b0;
      last_k_q    <= '0;
      row_valid_q <= 1'b0;
      row_data_q  <= N'(1);
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      start_row_q <= start_row_d;
      bitrev_q    <= bitrev_d;
      last_k_q    <= last_k_d;
      row_valid_q <= row_valid_d;
      row_data_q  <= row_data_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
    end
  end

  assign row_valid = row_valid_q;
  assign row_data  = row_data_q;
  assign row_idx   = row_idx_q;
  assign row_last  = row_last_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_polar_gen_row_streamer.sv
`default_nettype none
// ============================================================================
// tb_polar_gen_row_streamer : scoreboard bench, N_LOG=2 and N_LOG=3 instances
// Revision: 1.0
// ============================================================================
module tb_polar_gen_row_streamer;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] i;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N_LOG = 2 instance
  logic       start2, abort2, bitrev2, rdy2;
  logic [1:0] start_row2;
  logic [2:0] row_count2;
  logic       valid2, last2, busy2, done2;
  logic [3:0] data2;
  logic [1:0] idx2;

  // N_LOG = 3 instance
  logic       start3, abort3, bitrev3, rdy3;
  logic [2:0] start_row3;
  logic [3:0] row_count3;
  logic       valid3, last3, busy3, done3;
  logic [7:0] data3;
  logic [2:0] idx3;

  polar_gen_row_streamer #(.N_LOG(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .start_row(start_row2), .row_count(row_count2), .bitrev(bitrev2),
    .row_ready(rdy2), .row_valid(valid2), .row_data(data2), .row_idx(idx2),
    .row_last(last2), .busy(busy2), .done(done2)
  );

  polar_gen_row_streamer #(.N_LOG(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .start_row(start_row3), .row_count(row_count3), .bitrev(bitrev3),
    .row_ready(rdy3), .row_valid(valid3), .row_data(data3), .row_idx(idx3),
    .row_last(last3), .busy(busy3), .done(done3)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   dn2    = 0;
  int   dn3    = 0;
  exp_t q2[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitors: a beat transfers on valid & ready unless abort cancels it.
  always @(negedge clk) begin
    if (rst_n && valid2 && rdy2 && !abort2) begin
      if (q2.size() == 0) chk("d2 unexpected transfer", {60'd0, data2}, 64'hDEAD);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2 row_data", data2, e.d);
        chk("d2 row_idx",  idx2,  e.i);
        chk("d2 row_last", last2, e.l);
      end
    end
    if (done2) dn2++;
  end

  always @(negedge clk) begin
    if (rst_n && valid3 && rdy3 && !abort3) begin
      if (q3.size() == 0) chk("d3 unexpected transfer", {56'd0, data3}, 64'hDEAD);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("d3 row_data", data3, e.d);
        chk("d3 row_idx",  idx3,  e.i);
        chk("d3 row_last", last3, e.l);
      end
    end
    if (done3) dn3++;
  end

  task automatic push(input int which, input logic [7:0] d, input logic [2:0] i, input logic l);
    exp_t e;
    e.d = d; e.i = i; e.l = l;
    if (which == 2) q2.push_back(e);
    else q3.push_back(e);
  endtask

  // Called at posedge+1; start is held across exactly one active edge.
  task automatic go(input int which, input logic [2:0] sr, input logic [3:0] cnt, input logic br);
    if (which == 2) begin
      start2 = 1'b1; start_row2 = sr[1:0]; row_count2 = cnt[2:0]; bitrev2 = br;
    end else begin
      start3 = 1'b1; start_row3 = sr; row_count3 = cnt; bitrev3 = br;
    end
    @(posedge clk); #1;
    start2 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_done(input int which);
    int n = 0;
    while (((which == 2) ? done2 : done3) !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk((which == 2) ? "d2 done seen" : "d3 done seen",
        (which == 2) ? done2 : done3, 1'b1);
  endtask

  initial begin
    int n;
    int dc;
    rst_n = 1'b0;
    start2 = 0; abort2 = 0; bitrev2 = 0; rdy2 = 0; start_row2 = 0; row_count2 = 0;
    start3 = 0; abort3 = 0; bitrev3 = 0; rdy3 = 0; start_row3 = 0; row_count3 = 0;
    #12;
    chk("reset valid", valid2, 1'b0);
    chk("reset data",  data2,  4'h1);
    chk("reset idx",   idx2,   2'd0);
    chk("reset busy",  busy2,  1'b0);
    chk("reset done",  done2,  1'b0);
    chk("reset data3", data3,  8'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Natural full sequence, N=4
    rdy2 = 1'b1;
    push(2, 8'h1, 3'd0, 0); push(2, 8'h3, 3'd1, 0);
    push(2, 8'h5, 3'd2, 0); push(2, 8'hF, 3'd3, 1);
    go(2, 3'd0, 4'd0, 1'b0);
    chk("t1 latency valid", valid2, 1'b1);
    n = 0;
    while (busy2 && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t1 busy cycles", n, 4);
    chk("t1 done pulse", done2, 1'b1);
    chk("t1 valid after", valid2, 1'b0);
    @(posedge clk); #1;
    chk("t1 done one cycle", done2, 1'b0);

    // Wrap-around, N=8
    rdy3 = 1'b1;
    push(3, 8'h55, 3'd6, 0); push(3, 8'hFF, 3'd7, 0); push(3, 8'h01, 3'd0, 1);
    go(3, 3'd6, 4'd3, 1'b0);
    wait_done(3);
    @(posedge clk); #1;

    // Bit-reversed order, N=8
    push(3, 8'h11, 3'd4, 0); push(3, 8'h05, 3'd2, 1);
    go(3, 3'd1, 4'd2, 1'b1);
    wait_done(3);
    @(posedge clk); #1;

    // Clamped count (7 > 4) with bitrev and wrap, N=4
    push(2, 8'h3, 3'd1, 0); push(2, 8'hF, 3'd3, 0);
    push(2, 8'h1, 3'd0, 0); push(2, 8'h5, 3'd2, 1);
    go(2, 3'd2, 4'd7, 1'b1);
    wait_done(2);
    @(posedge clk); #1;

    // Back-pressure on the second row
    push(2, 8'h1, 3'd0, 0); push(2, 8'h3, 3'd1, 0);
    push(2, 8'h5, 3'd2, 0); push(2, 8'hF, 3'd3, 1);
    go(2, 3'd0, 4'd4, 1'b0);
    @(posedge clk); #1;
    rdy2 = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp data hold",  data2,  4'h3);
      chk("bp valid hold", valid2, 1'b1);
    end
    rdy2 = 1'b1;
    wait_done(2);
    @(posedge clk); #1;

    // Abort during row 2: no done pulse
    push(2, 8'h1, 3'd0, 0); push(2, 8'h3, 3'd1, 0);
    go(2, 3'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort row2 data", data2, 4'h5);
    abort2 = 1'b1;
    dc = dn2;
    @(posedge clk); #1;
    abort2 = 1'b0;
    chk("abort valid", valid2, 1'b0);
    chk("abort busy",  busy2,  1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort no done", dn2, dc);

    // Start while busy is ignored
    push(3, 8'h01, 3'd0, 0); push(3, 8'h03, 3'd1, 0);
    push(3, 8'h05, 3'd2, 0); push(3, 8'h0F, 3'd3, 1);
    go(3, 3'd0, 4'd4, 1'b0);
    start3 = 1'b1; start_row3 = 3'd5;
    @(posedge clk); #1;
    start3 = 1'b0;
    wait_done(3);
    // Start in the same cycle as done; single-row sequence
    push(3, 8'h55, 3'd6, 1);
    go(3, 3'd3, 4'd1, 1'b1);
    wait_done(3);
    @(posedge clk); #1;

    // Asynchronous reset mid-sequence
    rdy2 = 1'b0;
    go(2, 3'd0, 4'd0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("areset valid", valid2, 1'b0);
    chk("areset data",  data2,  4'h1);
    chk("areset idx",   idx2,   2'd0);
    chk("areset done",  done2,  1'b0);
    chk("areset busy",  busy2,  1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rdy2 = 1'b1;
    push(2, 8'hF, 3'd3, 0); push(2, 8'h1, 3'd0, 1);
    go(2, 3'd3, 4'd2, 1'b0);
    wait_done(2);
    repeat (3) @(posedge clk);
    #1;

    chk("q2 drained", q2.size(), 0);
    chk("q3 drained", q3.size(), 0);
    chk("d2 done count", dn2, 4);
    chk("d3 done count", dn3, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
